ram_stream_reader: RTL and testbench



---
 rtl/ram_pkg.sv | 22 ++
 rtl/rd_out_stage.sv | 51 +++++
 rtl/ram_stream_reader.sv | 153 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the 8x8 RAM family and its stream reader.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default word and address widths
//   RAM_DEPTH                       : number of words for the default width
//   rd_state_t                      : reader control states
// ---------------------------------------------------------------------------
package ram_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int RAM_DEPTH      = 2 ** DEFAULT_ADDR_W;

  // CSUM is only reachable when the checksum beat is compiled in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    CSUM = 2'd2,
    DONE = 2'd3
  } rd_state_t;

endpackage

// File: rtl/rd_out_stage.sv
// ---------------------------------------------------------------------------
// rd_out_stage
// One-entry registered valid/ready output slot. A new word may be loaded
// whenever the slot is empty or its current word is being accepted; while the
// downstream stalls the word and its last flag are held stable.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : write load_data/load_last into the slot (only when slot_free)
//   load_data   : word to present
//   load_last   : end-of-burst marker for that word
//   m_ready     : downstream ready
//   m_data      : registered stream data
//   m_valid     : slot holds a word
//   m_last      : registered end-of-burst marker
//   slot_free   : the slot can accept a load this cycle
// ---------------------------------------------------------------------------
module rd_out_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  output logic              slot_free
);

  assign slot_free = !m_valid || m_ready;

  // NOTE: state is updated with non-blocking assignments in an always_ff with
  // rst_n in the sensitivity list, so reset clears it without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_data  <= load_data;
      m_valid <= 1'b1;
      m_last  <= load_last;
    end else if (m_valid && m_ready) begin
      // Accepted with nothing behind it: empty the slot, keep the data bits.
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
// Walks a contiguous (wrapping) address range of a combinational-read RAM on a
// start command and streams each word out on a valid/ready interface.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : burst request, sampled only while idle
//   start_addr  : first address of the burst
//   len         : number of words, 0..2**ADDR_W (larger values are clamped)
//   busy        : burst in progress (low in the done cycle)
//   done        : one-cycle pulse at the end of a burst
//   ram_addr    : RAM read address
//   ram_dout    : RAM combinational read data
//   m_data, m_valid, m_ready, m_last : output stream
// Build option: define RAM_READER_CHECKSUM_EN to append one beat carrying the
// XOR of all data beats; that beat then carries m_last instead of the final
// data beat.
// ---------------------------------------------------------------------------
module ram_stream_reader
  import ram_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(2 ** ADDR_W);

  rd_state_t         state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              slot_free;
  logic              load;
  logic              data_load;
  logic [DATA_W-1:0] load_data;
  logic              load_last;

`ifdef RAM_READER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    data_load = 1'b0;
    load_data = ram_dout;
    load_last = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = READ;
      end
      READ: begin
        if (slot_free) begin
          if (remaining != '0) begin
            load      = 1'b1;
            data_load = 1'b1;
`ifdef RAM_READER_CHECKSUM_EN
            load_last = 1'b0;
`else
            load_last = (remaining == (ADDR_W + 1)'(1));
`endif
          end else begin
`ifdef RAM_READER_CHECKSUM_EN
            // All data beats are loaded; csum already includes the last one.
            load      = 1'b1;
            load_data = csum;
            load_last = 1'b1;
            state_nxt = CSUM;
`else
            // Nothing left to load and the slot is empty or its final beat
            // is being accepted right now.
            state_nxt = DONE;
`endif
          end
        end
      end
`ifdef RAM_READER_CHECKSUM_EN
      CSUM: begin
        if (m_valid && m_ready) state_nxt = DONE;
      end
`endif
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        ptr       <= start_addr;
        remaining <= (len > DEPTH_LEN) ? DEPTH_LEN : len;
      end else if (data_load) begin
        ptr       <= ptr + ADDR_W'(1);  // wraps modulo the RAM depth
        remaining <= remaining - (ADDR_W + 1)'(1);
      end
    end
  end

`ifdef RAM_READER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum <= '0;
    end else if (state == IDLE && start) begin
      csum <= '0;
    end else if (data_load) begin
      csum <= csum ^ ram_dout;
    end
  end
`endif

  assign busy     = (state == READ) || (state == CSUM);
  assign done     = (state == DONE);
  assign ram_addr = ptr;

  rd_out_stage #(
    .DATA_W (DATA_W)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_reader
// Self-checking bench for ram_stream_reader. Holds the 8x8 RAM contents, works
// out each burst's expected beat list from the RAM contents and the burst
// parameters, and compares every accepted beat plus the busy/done/address
// behaviour. Honours RAM_READER_CHECKSUM_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ram_stream_reader;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  logic [DW-1:0] mem [DEPTH];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  logic [15:0] ready_pat;

  assign ram_dout = mem[ram_addr];

  ram_stream_reader #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .ram_addr   (ram_addr),
    .ram_dout   (ram_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected beats: min(len, depth) consecutive words from start_addr,
  // wrapping; optionally followed by their XOR.
  task automatic build_expected(input int sa, input int ln);
    int n;
    logic [DW-1:0] x;
    beat_t b;
    n = (ln > DEPTH) ? DEPTH : ln;
    x = '0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      b.data = mem[(sa + i) % DEPTH];
      x      = x ^ b.data;
`ifdef RAM_READER_CHECKSUM_EN
      b.last = 1'b0;
`else
      b.last = (i == n - 1);
`endif
      exp_q.push_back(b);
    end
`ifdef RAM_READER_CHECKSUM_EN
    b.data = x;
    b.last = 1'b1;
    exp_q.push_back(b);
`endif
  endtask

  // pct < 0 selects the fixed per-cycle pattern in ready_pat.
  function automatic logic pick_ready(input int pct, input int cyc);
    if (pct < 0) return (cyc < 16) ? ready_pat[cyc] : 1'b1;
    return ($urandom_range(99) < pct);
  endfunction

  // Called at a negedge with the design idle.
  task automatic run_burst(input int sa, input int ln, input int pct, input bit stray_start);
    int  n_data, got, cycles, last_hs, first_valid;
    bit  done_seen, prev_stall, held_last;
    logic [DW-1:0] held_data;
    n_data = (ln > DEPTH) ? DEPTH : ln;
    build_expected(sa, ln);
    got = 0; cycles = 0; last_hs = -1; first_valid = -1;
    done_seen = 0; prev_stall = 0; held_data = '0; held_last = 0;

    start      = 1'b1;
    start_addr = AW'(sa);
    len        = (AW + 1)'(ln);
    step();
    start = 1'b0;

    while (!done_seen && cycles < 200) begin
      start = 1'b0;
      if (done) begin
        done_seen = 1;
        check("beat_count", got, exp_q.size());
        check("busy_in_done", busy, 0);
        check("valid_in_done", m_valid, 0);
        if (exp_q.size() > 0) begin
          check("done_after_last", cycles, last_hs + 1);
          check("first_beat_latency", first_valid, 1);
          if (pct == 100) check("full_throughput", last_hs, exp_q.size());
        end else begin
          check("done_empty_burst", cycles, 1);
        end
      end else begin
        check("busy", busy, 1);
        if (got + int'(m_valid) <= n_data)
          check("ram_addr", ram_addr, (sa + got + int'(m_valid)) % DEPTH);
        if (prev_stall) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, held_data);
          check("stall_last", m_last, held_last);
        end
        if (m_valid && first_valid < 0) first_valid = cycles;
        m_ready = pick_ready(pct, cycles);
        if (m_valid && m_ready) begin
          if (got < exp_q.size()) begin
            check("beat_data", m_data, exp_q[got].data);
            check("beat_last", m_last, exp_q[got].last);
          end else begin
            check("extra_beat", m_valid, 0);
          end
          got++;
          last_hs = cycles;
        end
        prev_stall = m_valid && !m_ready;
        held_data  = m_data;
        held_last  = m_last;
        if (stray_start && cycles == 2) begin
          start      = 1'b1;
          start_addr = AW'($urandom_range(DEPTH - 1));
          len        = (AW + 1)'($urandom_range(1, DEPTH));
        end
        step();
        cycles++;
      end
    end
    start = 1'b0;
    check("burst_timeout", done_seen, 1);
    step();
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    len        = '0;
    m_ready    = 1'b0;
    ready_pat  = 16'hFFFF;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(8'h10 + i);

    @(negedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    rst_n = 1'b1;
    step();

    // Basic burst: 12,13,14.
    run_burst(2, 3, 100, 0);
    // Wrap: 16,17,10,11 from addresses 6,7,0,1.
    run_burst(6, 4, 100, 0);
    // Backpressure pattern 1,0,0,1,1 from the first valid cycle.
    ready_pat = 16'hFFFF;
    ready_pat[2] = 1'b0;
    ready_pat[3] = 1'b0;
    run_burst(0, 3, -1, 0);
    ready_pat = 16'hFFFF;
    // Empty burst.
    run_burst(5, 0, 100, 0);
    // Oversized length clamps to the RAM depth.
    run_burst(5, 12, 100, 0);
    // Full sweep (checksum 00 when compiled in), then with mem[0]=A5 (B5).
    run_burst(0, 8, 100, 0);
    mem[0] = 8'hA5;
    run_burst(0, 8, 100, 0);
    // Start pulsed mid-burst is ignored.
    run_burst(3, 5, 70, 1);

    // Asynchronous reset mid-burst.
    start = 1'b1; start_addr = 3'd1; len = 4'd8; m_ready = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_last", m_last, 0);
    check("midrst_ram_addr", ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_burst(4, 2, 100, 0);

    // Randomized bursts over random RAM contents.
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      run_burst($urandom_range(DEPTH - 1), $urandom_range(15),
                $urandom_range(30, 100), 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
